// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hack_pkg
// Purpose : Shared constants and types for the Hack data-RAM arbiter.
//           Hack memory map: RAM 0..16383, screen 16384..24575,
//           keyboard register at 24576.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package hack_pkg;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 16;
  localparam int SCREEN_BASE = 16384;
  localparam int KBD_ADDR    = 24576;
  localparam int RAM_DEPTH   = 24577;

  localparam int N_PORTS     = 3;
  localparam int PORT_CPU    = 0;
  localparam int PORT_HOST   = 1;
  localparam int PORT_SCAN   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/hack_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : hack_rr_pick
// Purpose : Combinational N-way round-robin picker. The search starts at
//           (last+1) mod N and wraps; the first requesting port wins.
// Ports   : req   [N]  - request vector
//           last  [IW] - index of the most recently granted port
//           valid      - at least one request present
//           grant [IW] - index of the winning port (0 when !valid)
// Revision: 1.0 - initial release
// ============================================================================
module hack_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] grant
);

  // One extra bit holds last+i (at most 2N-1) before the wrap subtraction.
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    valid = 1'b0;
    grant = '0;
    w_sum = '0;
    w_idx = '0;
    for (int i = 1; i <= N; i++) begin
      w_sum = {1'b0, last} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_idx = w_sum[IW-1:0];
      if (!valid && req[w_idx]) begin
        valid = 1'b1;
        grant = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hack_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : hack_mem_arbiter
// Purpose : Shares one synchronous single-port data RAM between N requesters
//           (CPU, host loader, screen scan-out). Round-robin grant, a single
//           access in flight, req/ack handshake per port.
// Ports   : clk, rst              - clock, synchronous active-high reset
//           req/we [N]            - per-port request and write flag
//           addr  [N*ADDR_W]      - per-port word address (packed by port)
//           wdata [N*DATA_W]      - per-port write data (packed by port)
//           ack   [N]             - one-hot completion pulse
//           rdata [DATA_W]        - read data, valid while ack is high
//           ram_addr/ram_we/ram_wdata - RAM command outputs
//           ram_rdata             - RAM read data, one cycle after ram_addr
//           busy                  - an access is in flight
// Revision: 1.0 - initial release
// ============================================================================
module hack_mem_arbiter #(
  parameter int N      = hack_pkg::N_PORTS,
  parameter int ADDR_W = hack_pkg::ADDR_W,
  parameter int DATA_W = hack_pkg::DATA_W,
  parameter int DEPTH  = hack_pkg::RAM_DEPTH
) (
  input  logic                peri_unused_guard_n_a = 1'b0,
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        we,
  input  logic [N*ADDR_W-1:0] addr,
  input  logic [N*DATA_W-1:0] wdata,
  output logic [N-1:0]        ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy
);

  import hack_pkg::*;

  localparam int              IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  // r_g is both the in-flight port index and the round-robin "last" pointer:
  // the latch of g and the update of last happen on the same edge.
  logic [IW-1:0]     r_g;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_oor;

  logic [N-1:0]      w_gmask;
  logic [N-1:0]      w_pick_req;
  logic              w_pick_valid;
  logic [IW-1:0]     w_pick;
  logic              w_load;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;

  assign w_gmask     = {{(N-1){1'b0}}, 1'b1} << r_g;
  assign w_sel_addr  = addr[int'(w_pick)*ADDR_W +: ADDR_W];
  assign w_sel_wdata = wdata[int'(w_pick)*DATA_W +: DATA_W];
  assign w_sel_we    = we[w_pick];

  hack_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (w_pick_req),
    .last  (r_g),
    .valid (w_pick_valid),
    .grant (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pick_req  = '0;
    ack         = '0;
    rdata       = '0;
    case (r_state)
      IDLE: begin
        w_pick_req = req;
        if (w_pick_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        ack = w_gmask;
        if (!r_we && !r_oor) begin
          rdata = ram_rdata;
        end
        // The acked port may still hold req this cycle; it must not win again.
        w_pick_req = req & ~w_gmask;
        if (w_pick_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // An access abandoned by reset must not report completion.
    if (rst) begin
      ack   = '0;
      rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_g     <= IW'(N-1);
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_g     <= w_pick;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_we    <= w_sel_we;
        r_oor   <= ({1'b0, w_sel_addr} >= c_depth);
      end
    end
  end

  // Combinational ~rst gating so a reset landing in ISSUE never writes.
  assign ram_we    = (r_state == ISSUE) && r_we && !r_oor && !rst;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hack_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_hack_mem_arbiter
// Purpose : Self-checking bench for hack_mem_arbiter with a behavioural RAM
//           and an in-order scoreboard of expected (port, rdata) responses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hack_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 15;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata = '0;
  logic            busy;

  hack_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM covering the full 15-bit address space.
  logic [DW-1:0] mem [0:32767] = '{default: '0};
  logic          preload = 1'b1;
  always @(posedge clk) begin
    if (preload) mem[30000] <= 16'hDEAD;
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            we_cnt = 0;
  int            ack_total = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic [DW-1:0] last_we_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= ram_addr;
      last_we_data <= ram_wdata;
    end
    if (ack != '0) begin
      exp_t e;
      ack_total <= ack_total + 1;
      if (q.size() == 0) begin
        check("unexpected_ack", {29'd0, ack}, 32'd0);
      end else begin
        e = q.pop_front();
        check("ack_port", {29'd0, ack}, 32'(1 << e.port));
        check("rdata", {16'd0, rdata}, {16'd0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]            = r;
    we[p]             = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  task automatic push(input int p, input logic [DW-1:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic wait_ack(input int p, output int at);
    at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack[p]) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $error("FAIL ack_timeout port=%0d observed=none expected=ack", p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int at;
    int we0;
    int acks0;

    // ---- reset state ----
    step(); step(); step();
    @(negedge clk);
    check("rst_ack", {29'd0, ack}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    check("rst_ram_addr", {17'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {16'd0, ram_wdata}, 32'd0);

    // ---- CPU write 5 = 0x1234, then read it back ----
    step();
    rst = 1'b0;
    preload = 1'b0;
    we0 = we_cnt;
    drive(0, 1'b1, 1'b1, 15'd5, 16'h1234);
    push(0, 16'h0000);
    t0 = cyc;
    @(negedge clk);
    check("issue_not_yet_busy", {31'd0, busy}, 32'd0);
    wait_ack(0, at);
    check("wr_latency", at - t0, 32'd2);
    step();
    check("wr_pulse_count", we_cnt - we0, 32'd1);
    check("wr_addr", {17'd0, last_we_addr}, 32'd5);
    check("wr_data", {16'd0, last_we_data}, 32'h1234);
    we0 = we_cnt;
    drive(0, 1'b1, 1'b0, 15'd5, 16'h0000);
    push(0, 16'h1234);
    t0 = cyc;
    wait_ack(0, at);
    check("rd_latency", at - t0, 32'd2);
    step();
    drive(0, 1'b0, 1'b0, 15'd0, 16'h0000);
    check("rd_no_write", we_cnt - we0, 32'd0);

    // ---- fairness from reset: all three request ----
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 15'd5, 16'h0000);
    drive(1, 1'b1, 1'b0, 15'd16384, 16'h0000);
    drive(2, 1'b1, 1'b0, 15'd6, 16'h0000);
    push(0, 16'h1234);
    push(1, 16'h0000);
    push(2, 16'h0000);
    t0 = cyc;
    wait_ack(0, at);
    check("rr_ack0_cycle", at - t0, 32'd2);
    step();
    drive(0, 1'b1, 1'b0, 15'd7, 16'h0000);
    push(0, 16'h0000);
    wait_ack(1, at);
    check("rr_ack1_cycle", at - t0, 32'd4);
    step();
    drive(1, 1'b0, 1'b0, 15'd0, 16'h0000);
    wait_ack(2, at);
    check("rr_ack2_cycle", at - t0, 32'd6);
    step();
    drive(2, 1'b0, 1'b0, 15'd0, 16'h0000);
    wait_ack(0, at);
    check("rr_wrap_ack0_cycle", at - t0, 32'd8);
    step();
    drive(0, 1'b0, 1'b0, 15'd0, 16'h0000);

    // ---- scan-out continuous read vs CPU write to screen base ----
    drive(2, 1'b1, 1'b0, 15'd16384, 16'h0000);
    push(2, 16'h0000);
    step();
    drive(0, 1'b1, 1'b1, 15'd16384, 16'h00FF);
    push(0, 16'h0000);
    push(2, 16'h00FF);
    t0 = cyc;
    wait_ack(2, at);
    step();
    wait_ack(0, at);
    check("cpu_served_cycle", at - t0, 32'd3);
    step();
    drive(0, 1'b0, 1'b0, 15'd0, 16'h0000);
    wait_ack(2, at);
    check("scan_after_cpu_cycle", at - t0, 32'd5);
    step();
    drive(2, 1'b0, 1'b0, 15'd0, 16'h0000);

    // ---- out-of-range host write and read ----
    we0 = we_cnt;
    drive(1, 1'b1, 1'b1, 15'd30000, 16'hABCD);
    push(1, 16'h0000);
    t0 = cyc;
    wait_ack(1, at);
    check("oor_wr_latency", at - t0, 32'd2);
    step();
    check("oor_wr_suppressed", we_cnt - we0, 32'd0);
    drive(1, 1'b1, 1'b0, 15'd30000, 16'h0000);
    push(1, 16'h0000);
    t0 = cyc;
    wait_ack(1, at);
    check("oor_rd_latency", at - t0, 32'd2);
    step();
    drive(1, 1'b0, 1'b0, 15'd0, 16'h0000);
    check("oor_mem_untouched", {16'd0, mem[30000]}, 32'h0000DEAD);

    // ---- reset during ISSUE of a write ----
    we0   = we_cnt;
    acks0 = ack_total;
    drive(0, 1'b1, 1'b1, 15'd9, 16'h5555);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_issue_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_issue_ack", {29'd0, ack}, 32'd0);
    step();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 15'd0, 16'h0000);
    @(negedge clk);
    check("rst_issue_idle", {31'd0, busy}, 32'd0);
    check("rst_issue_ack_next", {29'd0, ack}, 32'd0);
    step();
    check("rst_issue_no_write", we_cnt - we0, 32'd0);
    check("rst_issue_no_ackpulse", ack_total - acks0, 32'd0);
    check("rst_issue_mem", {16'd0, mem[9]}, 32'd0);
    drive(0, 1'b1, 1'b0, 15'd9, 16'h0000);
    push(0, 16'h0000);
    wait_ack(0, at);
    step();
    drive(0, 1'b0, 1'b0, 15'd0, 16'h0000);

    // ---- withdrawal after sampling: access still completes ----
    drive(1, 1'b1, 1'b0, 15'd5, 16'h0000);
    push(1, 16'h1234);
    t0 = cyc;
    step();
    drive(1, 1'b0, 1'b0, 15'd0, 16'h0000);
    wait_ack(1, at);
    check("withdraw_late_ack", at - t0, 32'd2);

    // ---- withdrawal before sampling: no access ----
    step();
    acks0 = ack_total;
    req[2] = 1'b1;
    #2;
    req[2] = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("withdraw_early_idle", {31'd0, busy}, 32'd0);
    step();
    check("withdraw_early_no_ack", ack_total - acks0, 32'd0);

    check("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
